imm_extend_unit: RTL and testbench
==================================

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 Parameter IN_W, default 16, SHALL set the immediate input width in bits; legal range 1..OUT_W.
REQ-002 Parameter OUT_W, default 32, SHALL set the extended output width in bits; legal range IN_W..64.
REQ-003 Parameter SHIFT, default 2, SHALL set the left-shift amount for mode 3; legal range 0..OUT_W-IN_W.
REQ-004 Parameter TAG_W, default 5, SHALL set the sideband tag width in bits, for example a destination register index.
REQ-005 clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 rst, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-007 in_valid, input, 1 bit, SHALL indicate that the upstream beat is valid.
REQ-008 in_ready, output, 1 bit, SHALL indicate that the unit can accept a beat this cycle.
REQ-009 a, input, IN_W bits, SHALL carry the raw immediate field.
REQ-010 mode, input, 2 bits, SHALL select the operation: 0 sign-extend, 1 zero-extend, 2 load-upper, 3 sign-extend-then-shift.
REQ-011 tag_in, input, TAG_W bits, SHALL carry the sideband tag that is passed through unchanged with the beat.
REQ-012 out_valid, output, 1 bit, SHALL indicate that out and tag_out are valid.
REQ-013 out_ready, input, 1 bit, SHALL indicate that the downstream consumer accepts the beat.
REQ-014 out, output, OUT_W bits, SHALL carry the extended immediate.
REQ-015 tag_out, output, TAG_W bits, SHALL carry the tag associated with out.

Function
REQ-016 A beat SHALL be accepted in any cycle where in_valid and in_ready are both 1, and delivered in any cycle where out_valid and out_ready are both 1.
REQ-017 Mode 0 SHALL produce a with bit IN_W-1 replicated into bits OUT_W-1..IN_W.
REQ-018 Mode 1 SHALL produce a with bits OUT_W-1..IN_W cleared to zero.
REQ-019 Mode 2 SHALL place a in bits OUT_W-1..OUT_W-IN_W and set all lower bits to zero.
REQ-020 Mode 3 SHALL produce the mode-0 result shifted left by SHIFT, with zero fill and truncation to OUT_W.
REQ-021 When IN_W equals OUT_W, modes 0, 1 and 2 SHALL all pass a through unchanged.
REQ-022 Extension SHALL be computed combinationally at acceptance, and the registered result SHALL be stored.
- Latency: 1 cycle from acceptance to out_valid.
REQ-023 Buffering SHALL be a two-entry skid buffer: a main register driving out/tag_out, plus one skid register.
REQ-024 The buffer SHALL have exactly three states, with in_ready = (state != FULL), a registered value only.
- EMPTY: out_valid=0.
- ONE: main register full, skid register empty.
- FULL: both registers full.
REQ-025 In EMPTY, an accepted beat SHALL be loaded into main and the state SHALL move to ONE.
REQ-026 In ONE, transitions SHALL be:
- accept and deliver in the same cycle: main reloads, state stays ONE.
- deliver only: state moves to EMPTY.
- accept only: the beat is loaded into skid, state moves to FULL.
REQ-027 In FULL, no beat SHALL be accepted; on deliver, skid SHALL move to main and the state SHALL move to ONE.
REQ-028 Beats SHALL be delivered strictly in acceptance order; none SHALL be lost or duplicated.
REQ-029 With out_ready held at 1, throughput SHALL be 1 beat per cycle.
REQ-030 out and tag_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-031 a, mode and tag_in SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-032 Asserting rst SHALL immediately force state to EMPTY, out_valid=0, in_ready=0, out=0, tag_out=0, and skid contents=0, independent of clk.
REQ-033 On the first rising clk edge after rst deasserts, in_ready SHALL become 1.
REQ-034 Any beats in flight when rst asserts SHALL be discarded.

Verification
REQ-035 Defaults, out_ready=1; a=16'h01C8 (456), mode 0 -> one cycle later out=32'h000001C8, out_valid=1 for exactly one cycle.
REQ-036 a=16'hFF78 (-136) in mode 0 then mode 1 on consecutive cycles -> out=32'hFFFFFF78, then 32'h0000FF78, on consecutive cycles.
REQ-037 a=16'h1234 mode 2, then a=16'hFFFF mode 3 -> out=32'h12340000, then 32'hFFFFFFFC; also a=16'h7FFF mode 3 -> 32'h0001FFFC.
REQ-038 out_ready=0 with beats tagged 1,2,3 offered back-to-back -> tags 1 and 2 accepted and in_ready=0; on release, tag_out=1,2,3 in order with no gaps.
REQ-039 rst asserted mid-cycle while FULL -> out_valid=0 at once with no clock edge; after release a new beat returns correct data, and the old beats never appear.
REQ-040 IN_W=32, OUT_W=32 instance; a=32'h80000000 in modes 0, 1, 2 -> out=32'h80000000 each time.

Source files
------------

// File: rtl/imm_extend_unit.sv
// Immediate extension unit: sign/zero/load-upper/shifted extension of an
// immediate field, delivered through a two-entry skid buffer with a sideband tag.
module imm_extend_unit #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   main_val_q, main_val_d;
  logic [TAG_W-1:0]   main_tag_q, main_tag_d;
  logic [OUT_W-1:0]   skid_val_q, skid_val_d;
  logic [TAG_W-1:0]   skid_tag_q, skid_tag_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               accept_c;
  logic               deliver_c;
  logic [OUT_W-1:0]   sext_c;
  logic [OUT_W-1:0]   ext_c;

  assign accept_c  = in_valid && in_ready_q;
  assign deliver_c = out_valid_q && out_ready;

  // Extension datapath, evaluated on the incoming beat
  always_comb begin
    sext_c = OUT_W'($signed(a));
    ext_c  = sext_c;
    case (mode)
      2'd0: ext_c = sext_c;
      2'd1: ext_c = OUT_W'(a);
      2'd2: ext_c = OUT_W'(a) << PAD_W;
      2'd3: ext_c = sext_c << SHIFT;
      default: ext_c = sext_c;
    endcase
  end

  // Skid buffer next-state and register loads
  always_comb begin
    state_d    = state_q;
    main_val_d = main_val_q;
    main_tag_d = main_tag_q;
    skid_val_d = skid_val_q;
    skid_tag_d = skid_tag_q;

    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          main_val_d = ext_c;
          main_tag_d = tag_in;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept_c && deliver_c) begin
          main_val_d = ext_c;
          main_tag_d = tag_in;
        end else if (deliver_c) begin
          state_d = EMPTY;
        end else if (accept_c) begin
          skid_val_d = ext_c;
          skid_tag_d = tag_in;
          state_d    = FULL;
        end
      end
      FULL: begin
        if (deliver_c) begin
          main_val_d = skid_val_q;
          main_tag_d = skid_tag_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_val_q  <= '0;
      main_tag_q  <= '0;
      skid_val_q  <= '0;
      skid_tag_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_val_q  <= main_val_d;
      main_tag_q  <= main_tag_d;
      skid_val_q  <= skid_val_d;
      skid_tag_q  <= skid_tag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = main_val_q;
  assign tag_out   = main_tag_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Bench for imm_extend_unit: FIFO-occupancy model with arithmetic extension
// reference, checked every cycle, plus directed literal expectations.
module tb_imm_extend_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [1:0]  mode;
  logic [4:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [4:0]  tag_out;

  logic        v2;
  logic        ir2;
  logic [31:0] a2;
  logic [1:0]  m2;
  logic [4:0]  t2;
  logic        ov2;
  logic [31:0] out2;
  logic [4:0]  tag2o;

  int checks;
  int failures;

  imm_extend_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .mode(mode), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .tag_out(tag_out)
  );

  imm_extend_unit #(.IN_W(32), .OUT_W(32), .SHIFT(0), .TAG_W(5)) dut_w (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2),
    .a(a2), .mode(m2), .tag_in(t2), .out_valid(ov2),
    .out_ready(1'b1), .out(out2), .tag_out(tag2o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Reference extension from plain 64-bit arithmetic
  function automatic logic [63:0] ext_model(input logic [63:0] av, input int m,
                                            input int in_w, input int out_w, input int sh);
    logic [63:0]        im;
    logic [63:0]        om;
    logic [63:0]        r;
    logic [63:0]        x;
    logic signed [63:0] s;
    im = (in_w >= 64) ? '1 : ((64'd1 << in_w) - 64'd1);
    om = (out_w >= 64) ? '1 : ((64'd1 << out_w) - 64'd1);
    x  = av & im;
    s  = $signed(x << (64 - in_w)) >>> (64 - in_w);
    case (m)
      0:       r = s;
      1:       r = x;
      2:       r = x << (out_w - in_w);
      default: r = 64'(s) << sh;
    endcase
    return r & om;
  endfunction

  typedef struct {
    logic [31:0] val;
    logic [4:0]  tag;
  } beat_t;

  beat_t q[$];
  bit    armed;

  // Model: beats in flight in acceptance order, capacity two
  always @(posedge clk) begin
    bit    acc;
    bit    del;
    beat_t b;
    if (rst) begin
      q.delete();
      armed = 1'b0;
    end else begin
      acc = in_valid && armed && (q.size() < 2);
      del = (q.size() > 0) && out_ready;
      b.val = 32'(ext_model(64'(a), int'(mode), 16, 32, 2));
      b.tag = tag_in;
      if (del) void'(q.pop_front());
      if (acc) q.push_back(b);
      armed = 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_tag_out", 64'(tag_out), 64'd0);
    end else begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(armed && (q.size() < 2)));
      if (q.size() > 0) begin
        chk("out", 64'(out), 64'(q[0].val));
        chk("tag_out", 64'(tag_out), 64'(q[0].tag));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] av, input logic [1:0] m, input logic [4:0] t);
    in_valid = v;
    a        = av;
    mode     = m;
    tag_in   = t;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    v2 = 1'b0; a2 = '0; m2 = '0; t2 = '0;

    // Reset and release
    #2;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd0);
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // Single sign-extend beat, valid for exactly one cycle
    drive(1'b1, 16'h01C8, 2'd0, 5'd4);
    step();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("m0_pos_valid", 64'(out_valid), 64'd1);
    chk("m0_pos_out", 64'(out), 64'h0000_01C8);
    step();
    chk("m0_pos_one_cycle", 64'(out_valid), 64'd0);

    // Negative value sign- then zero-extended back to back
    drive(1'b1, 16'hFF78, 2'd0, 5'd5);
    step();
    drive(1'b1, 16'hFF78, 2'd1, 5'd6);
    chk("m0_neg_out", 64'(out), 64'hFFFF_FF78);
    step();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("m1_out", 64'(out), 64'h0000_FF78);
    chk("m1_valid", 64'(out_valid), 64'd1);

    // Load-upper and shifted sign extension
    drive(1'b1, 16'h1234, 2'd2, 5'd7);
    step();
    drive(1'b1, 16'hFFFF, 2'd3, 5'd8);
    chk("m2_out", 64'(out), 64'h1234_0000);
    step();
    drive(1'b1, 16'h7FFF, 2'd3, 5'd9);
    chk("m3_neg_out", 64'(out), 64'hFFFF_FFFC);
    step();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("m3_pos_out", 64'(out), 64'h0001_FFFC);
    step();

    // Backpressure: fill both entries, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 2'd1, 5'd1);
    step();
    drive(1'b1, 16'h0022, 2'd1, 5'd2);
    step();
    drive(1'b1, 16'h0033, 2'd1, 5'd3);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_tag_head", 64'(tag_out), 64'd1);
    step();
    out_ready = 1'b1;
    chk("stall_tag_stable", 64'(tag_out), 64'd1);
    chk("stall_out_stable", 64'(out), 64'h0000_0011);
    step();
    chk("drain_tag2", 64'(tag_out), 64'd2);
    step();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("drain_tag3", 64'(tag_out), 64'd3);
    chk("drain_out3", 64'(out), 64'h0000_0033);
    step();
    chk("drain_done", 64'(out_valid), 64'd0);

    // Mid-cycle reset while full
    out_ready = 1'b0;
    drive(1'b1, 16'h0077, 2'd1, 5'd7);
    step();
    drive(1'b1, 16'h0088, 2'd1, 5'd8);
    step();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out", 64'(out), 64'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 16'h0042, 2'd1, 5'd9);
    step();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("post_rst_out", 64'(out), 64'h0000_0042);
    chk("post_rst_tag", 64'(tag_out), 64'd9);
    step();
    chk("post_rst_no_stale", 64'(out_valid), 64'd0);

    // Mixed traffic with irregular valid/ready patterns
    for (int i = 0; i < 48; i++) begin
      drive((i % 3) != 2, 16'(i * 16'h1357) ^ 16'h8421, 2'(i), 5'(i));
      out_ready = ((i % 5) != 1) && ((i % 7) != 3);
      step();
    end
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    out_ready = 1'b1;
    step(); step(); step();

    // Full-width instance: every non-shift mode passes through
    for (int m = 0; m < 3; m++) begin
      v2 = 1'b1; a2 = 32'h8000_0000; m2 = 2'(m); t2 = 5'(m + 20);
      step();
      chk("w32_valid", 64'(ov2), 64'd1);
      chk("w32_out", 64'(out2), 64'h8000_0000);
      chk("w32_model", 64'(out2), ext_model(64'h8000_0000, m, 32, 32, 0));
      chk("w32_tag", 64'(tag2o), 64'(m + 20));
    end
    v2 = 1'b0;
    step();
    chk("w32_idle", 64'(ov2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
